operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Pipeline stage directly upstream of the 3-read/2-write general register file.
- Takes decoded instructions, drives the three register-file read addresses and forwards both write-back ports.
- Tracks outstanding writes in a scoreboard and stalls on hazards.
- Registers the resolved operands to the execute stage behind a valid/ready handshake.

Parameters:
WORD_W, `WORD_LENGTH (32), operand/data width
REG_CNT, 16, number of general registers
REG_IDX_W, 4, register index width (log2 REG_CNT)
INSTR_W, 32, passthrough instruction word width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  INSTR_W  instruction word, passed through
in_src_a / in_src_b / in_src_x  in  REG_IDX_W each  source register indices
in_use_a / in_use_b / in_use_x  in  1 each  source actually read
in_rd  in  REG_IDX_W  destination register
in_rd_we  in  1  instruction writes in_rd
rf_raddr_a / rf_raddr_b / rf_raddr_x  out  REG_IDX_W each  register file read addresses (= in_src_*)
rf_rdata_a / rf_rdata_b / rf_rdata_x  in  WORD_W each  register file read data, combinational same cycle
wb0_en, wb1_en  in  1 each  write-back commit this cycle
wb0_addr, wb1_addr  in  REG_IDX_W each  write-back register
wb0_data, wb1_data  in  WORD_W each  write-back data
flush  in  1  discard stage output register
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
out_instr  out  INSTR_W  registered instruction
out_opnd_a / out_opnd_b / out_opnd_x  out  WORD_W each  resolved operands
out_rd  out  REG_IDX_W  registered destination
out_rd_we  out  1  registered write flag

Behaviour:
- Reset (async, rst_n low):
  - out_valid, out_rd_we = 0; out_instr, out_opnd_*, out_rd = 0.
  - All scoreboard bits = 0.
  - Reset mid-stall drops the held instruction.
- Register 0 reads as zero and is never pending. Writes to R0 are ignored by the scoreboard.
- Operand resolution per source s, combinational:
  - wb1 match (wb1_en && wb1_addr==src, src!=0) -> wb1_data.
  - Else wb0 match -> wb0_data.
  - Else rf_rdata_s.
  - Unused sources (in_use_s = 0) produce 0.
  - wb1 wins over wb0, the same priority the register file applies on a same-address double write.
- Hazard:
  - A used source is pending and not matched by this cycle's wb0/wb1, OR
  - in_rd_we && in_rd pending (WAW) and not cleared this cycle.
- in_ready = (!out_valid || out_ready) && !hazard. in_ready may depend combinationally on the in_* fields.
- Accept (in_valid && in_ready): next edge loads the out_* registers and sets out_valid = 1. Latency is 1 cycle.
- Hold: out_valid && !out_ready -> all out_* are stable.
- Drain: out_ready && !accept -> out_valid goes to 0.
- Scoreboard, REG_CNT bits, per edge:
  - Clear the bit for each wbN_en address.
  - Set the bit for in_rd when accept && in_rd_we && in_rd != 0.
  - Set wins over clear on the same register in the same cycle.
- flush:
  - Next edge out_valid = 0, and in_ready is forced 0 that cycle.
  - Scoreboard bits set by the flushed instruction are cleared; the owner is tracked by out_rd/out_rd_we.
  - Write-back clears still apply during flush.
- No internal state machine beyond the valid bit. States are EMPTY (out_valid = 0) and FULL (out_valid = 1); transitions are as above.

Decomposition:
- Shared package (defines): WORD_LENGTH, REG_CNT, REG_IDX_W.
- Shared package (types): an operand-bundle typedef (instr, opnd_a/b/x, rd, rd_we) for stage-to-stage registers, and a write-back port typedef (en, addr, data) reused by the register file and the execute/memory stages.
- Sub-module reg_scoreboard:
  - Holds the pending bits.
  - Takes set port, two clear ports and flush-owner clear.
  - Provides pending lookup for 4 indices.

Test Plan:
- Reset then accept instr src_a=3, src_b=5, rf returns 0x11/0x22, rd=7 we=1. Next cycle: out_valid=1, opnd_a=0x11, opnd_b=0x22, scoreboard[7]=1.
- Follow with an instr reading R7 while wb idle. Required: in_ready=0 for every cycle until wb0_en addr=7 data=0xCAFE. In that cycle in_ready=1 and out_opnd_a=0xCAFE next edge.
- wb0 and wb1 both write R4 (0xAAAA / 0xBBBB) while an instr reads R4. Required: operand = 0xBBBB.
- Source R0 with rf_rdata=0xFFFF_FFFF and wb0 addr=0. Required: operand 0, no stall; an instr with rd=0 never sets pending.
- out_ready=0 for 3 cycles with out_valid=1. Required: out_* stable, in_ready=0; on out_ready=1, a new instr is accepted in the same cycle.
- Accept instr rd=9, flush next cycle with out_ready=0. Required: out_valid=0; scoreboard[9]=0; an instr reading R9 proceeds without stall. Assert rst_n low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared widths, stage bundle and write-back port types
package operand_fetch_stage_pkg;
  localparam int WORD_LENGTH = 32;
  localparam int REG_CNT = 16;
  localparam int REG_IDX_W = 4;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [WORD_LENGTH-1:0] opnd_a;
    logic [WORD_LENGTH-1:0] opnd_b;
    logic [WORD_LENGTH-1:0] opnd_x;
    logic [REG_IDX_W-1:0] rd;
    logic rd_we;
  } opnd_bundle_t;
  typedef struct packed {
    logic en;
    logic [REG_IDX_W-1:0] addr;
    logic [WORD_LENGTH-1:0] data;
  } wb_port_t;
  // R0 is hardwired zero, so a write-back to it never matches a source
  function automatic logic wb_hit(input wb_port_t p, input logic [REG_IDX_W-1:0] idx);
    return p.en && p.addr == idx && idx != '0;
  endfunction
endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// operand_fetch_stage_reg_scoreboard: pending-write bits with set, two clears and owner clear
module operand_fetch_stage_reg_scoreboard
  import operand_fetch_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_addr,
  input  logic                 clr0_en,
  input  logic [REG_IDX_W-1:0] clr0_addr,
  input  logic                 clr1_en,
  input  logic [REG_IDX_W-1:0] clr1_addr,
  input  logic                 own_en,
  input  logic [REG_IDX_W-1:0] own_addr,
  input  logic [REG_IDX_W-1:0] q_addr [4],
  output logic [3:0]           q_pend
);
  logic [REG_CNT-1:0] bits, nxt;
  always_comb begin
    nxt = bits;
    if (clr0_en) nxt[clr0_addr] = 1'b0;
    if (clr1_en) nxt[clr1_addr] = 1'b0;
    if (own_en) nxt[own_addr] = 1'b0;
    if (set_en) nxt[set_addr] = 1'b1;
    nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bits <= '0;
    else bits <= nxt;
  for (genvar g = 0; g < 4; g++) begin : g_look
    assign q_pend[g] = bits[q_addr[g]];
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register-file read, write-back bypass, hazard stall and operand register
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int WORD_W = WORD_LENGTH
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [REG_IDX_W-1:0] in_src_a,
  input  logic [REG_IDX_W-1:0] in_src_b,
  input  logic [REG_IDX_W-1:0] in_src_x,
  input  logic                 in_use_a,
  input  logic                 in_use_b,
  input  logic                 in_use_x,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_rd_we,
  output logic [REG_IDX_W-1:0] rf_raddr_a,
  output logic [REG_IDX_W-1:0] rf_raddr_b,
  output logic [REG_IDX_W-1:0] rf_raddr_x,
  input  logic [WORD_W-1:0]    rf_rdata_a,
  input  logic [WORD_W-1:0]    rf_rdata_b,
  input  logic [WORD_W-1:0]    rf_rdata_x,
  input  logic                 wb0_en,
  input  logic [REG_IDX_W-1:0] wb0_addr,
  input  logic [WORD_W-1:0]    wb0_data,
  input  logic                 wb1_en,
  input  logic [REG_IDX_W-1:0] wb1_addr,
  input  logic [WORD_W-1:0]    wb1_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [WORD_W-1:0]    out_opnd_a,
  output logic [WORD_W-1:0]    out_opnd_b,
  output logic [WORD_W-1:0]    out_opnd_x,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_rd_we
);
  wb_port_t wb0, wb1;
  opnd_bundle_t d, q;
  logic [REG_IDX_W-1:0] q_addr [4];
  logic [3:0] pend;
  logic hazard, accept;
  assign wb0 = '{en: wb0_en, addr: wb0_addr, data: wb0_data};
  assign wb1 = '{en: wb1_en, addr: wb1_addr, data: wb1_data};
  function automatic logic cleared(input logic [REG_IDX_W-1:0] idx);
    return wb_hit(wb0, idx) || wb_hit(wb1, idx);
  endfunction
  // wb1 outranks wb0, matching the register file's same-address double-write order
  function automatic logic [WORD_W-1:0] resolve(input logic en, input logic [REG_IDX_W-1:0] src,
                                                input logic [WORD_W-1:0] rf);
    return !en ? '0 : wb_hit(wb1, src) ? wb1.data : wb_hit(wb0, src) ? wb0.data : src == '0 ? '0 : rf;
  endfunction
  assign rf_raddr_a = in_src_a;
  assign rf_raddr_b = in_src_b;
  assign rf_raddr_x = in_src_x;
  assign q_addr = '{in_src_a, in_src_b, in_src_x, in_rd};
  assign hazard = (in_use_a && pend[0] && !cleared(in_src_a)) ||
                  (in_use_b && pend[1] && !cleared(in_src_b)) ||
                  (in_use_x && pend[2] && !cleared(in_src_x)) ||
                  (in_rd_we && pend[3] && !cleared(in_rd));
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept = in_valid && in_ready;
  assign d = '{instr: in_instr, opnd_a: resolve(in_use_a, in_src_a, rf_rdata_a),
               opnd_b: resolve(in_use_b, in_src_b, rf_rdata_b),
               opnd_x: resolve(in_use_x, in_src_x, rf_rdata_x), rd: in_rd, rd_we: in_rd_we};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      q <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q <= d;
    end else if (flush || out_ready) out_valid <= 1'b0;
  operand_fetch_stage_reg_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (accept && in_rd_we),
    .set_addr  (in_rd),
    .clr0_en   (wb0_en),
    .clr0_addr (wb0_addr),
    .clr1_en   (wb1_en),
    .clr1_addr (wb1_addr),
    .own_en    (flush && out_valid && q.rd_we),
    .own_addr  (q.rd),
    .q_addr    (q_addr),
    .q_pend    (pend)
  );
  assign out_instr = q.instr;
  assign out_opnd_a = q.opnd_a;
  assign out_opnd_b = q.opnd_b;
  assign out_opnd_x = q.opnd_x;
  assign out_rd = q.rd;
  assign out_rd_we = q.rd_we;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: scoreboard-queue bench for the operand fetch stage
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;
  logic clk, rst_n, in_valid, in_ready, in_use_a, in_use_b, in_use_x, in_rd_we;
  logic [31:0] in_instr, out_instr;
  logic [3:0] in_src_a, in_src_b, in_src_x, in_rd, rf_raddr_a, rf_raddr_b, rf_raddr_x;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_rdata_x;
  logic wb0_en, wb1_en, flush, out_valid, out_ready, out_rd_we;
  logic [3:0] wb0_addr, wb1_addr, out_rd;
  logic [31:0] wb0_data, wb1_data, out_opnd_a, out_opnd_b, out_opnd_x;
  logic [31:0] rf_mem [16];
  logic [15:0] mp;
  logic mv;
  opnd_bundle_t exp_q[$];
  int n_cmp = 0, n_err = 0;

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_src_x(in_src_x),
    .in_use_a(in_use_a), .in_use_b(in_use_b), .in_use_x(in_use_x),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_raddr_x(rf_raddr_x),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_rdata_x(rf_rdata_x),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_opnd_a(out_opnd_a), .out_opnd_b(out_opnd_b), .out_opnd_x(out_opnd_x),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  assign rf_rdata_a = rf_mem[rf_raddr_a];
  assign rf_rdata_b = rf_mem[rf_raddr_b];
  assign rf_rdata_x = rf_mem[rf_raddr_x];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic bhit(input logic [3:0] s);
    return s != 0 && ((wb0_en && wb0_addr == s) || (wb1_en && wb1_addr == s));
  endfunction

  function automatic logic [31:0] bres(input logic en, input logic [3:0] s);
    if (!en || s == 0) return 32'h0;
    if (wb1_en && wb1_addr == s) return wb1_data;
    if (wb0_en && wb0_addr == s) return wb0_data;
    return rf_mem[s];
  endfunction

  task automatic idle();
    in_valid = 0; in_instr = 0; in_src_a = 0; in_src_b = 0; in_src_x = 0;
    in_use_a = 0; in_use_b = 0; in_use_x = 0; in_rd = 0; in_rd_we = 0;
    wb0_en = 0; wb0_addr = 0; wb0_data = 0; wb1_en = 0; wb1_addr = 0; wb1_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [31:0] w, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] x, input logic [2:0] u, input logic [3:0] rd, input logic we);
    in_valid = 1; in_instr = w; in_src_a = a; in_src_b = b; in_src_x = x;
    {in_use_a, in_use_b, in_use_x} = u; in_rd = rd; in_rd_we = we;
  endtask

  // one clock: predict readiness, compare/retire the queued head, push on accept
  task automatic tick();
    opnd_bundle_t e;
    logic haz, er, acc, own_we;
    logic [3:0] own_rd;
    #1;
    haz = (in_use_a && mp[in_src_a] && !bhit(in_src_a)) || (in_use_b && mp[in_src_b] && !bhit(in_src_b)) ||
          (in_use_x && mp[in_src_x] && !bhit(in_src_x)) || (in_rd_we && mp[in_rd] && !bhit(in_rd));
    er = (!mv || out_ready) && !haz && !flush;
    check("in_ready", 32'(in_ready), 32'(er));
    check("raddr", 32'({rf_raddr_a, rf_raddr_b, rf_raddr_x}), 32'({in_src_a, in_src_b, in_src_x}));
    own_we = 0;
    own_rd = 0;
    if (mv && exp_q.size() > 0) begin
      e = exp_q[0];
      own_we = e.rd_we;
      own_rd = e.rd;
      check("out_instr", out_instr, e.instr);
      check("out_opnd_a", out_opnd_a, e.opnd_a);
      check("out_opnd_b", out_opnd_b, e.opnd_b);
      check("out_opnd_x", out_opnd_x, e.opnd_x);
      check("out_rd", 32'({out_rd, out_rd_we}), 32'({e.rd, e.rd_we}));
      if (flush || out_ready) void'(exp_q.pop_front());
    end
    acc = in_valid && er;
    if (acc) exp_q.push_back('{in_instr, bres(in_use_a, in_src_a), bres(in_use_b, in_src_b),
                               bres(in_use_x, in_src_x), in_rd, in_rd_we});
    if (wb0_en) mp[wb0_addr] = 0;
    if (wb1_en) mp[wb1_addr] = 0;
    if (flush && mv && own_we) mp[own_rd] = 0;
    if (acc && in_rd_we) mp[in_rd] = 1;
    mp[0] = 0;
    mv = acc || (mv && !flush && !out_ready);
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(mv));
    if (wb0_en && wb0_addr != 0) rf_mem[wb0_addr] = wb0_data;
    if (wb1_en && wb1_addr != 0) rf_mem[wb1_addr] = wb1_data;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 32'h1000_0000 | i;
    rf_mem[0] = 32'hFFFF_FFFF;
    rf_mem[3] = 32'h11;
    rf_mem[5] = 32'h22;
    mp = 0;
    mv = 0;
    rst_n = 0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_instr", out_instr, 0);
    check("rst_opnd", out_opnd_a | out_opnd_b | out_opnd_x, 0);
    check("rst_rd", 32'({out_rd, out_rd_we}), 0);
    rst_n = 1;
    @(negedge clk);
    // RAW through the scoreboard, released by a wb0 write
    issue(32'hA1, 3, 5, 0, 3'b110, 7, 1);
    tick();
    check("t1_a", out_opnd_a, 32'h11);
    check("t1_b", out_opnd_b, 32'h22);
    issue(32'hA2, 7, 0, 0, 3'b100, 8, 1);
    repeat (3) begin
      tick();
      check("t2_stall", 32'(in_ready), 0);
    end
    wb0_en = 1; wb0_addr = 7; wb0_data = 32'hCAFE;
    #1 check("t2_release", 32'(in_ready), 1);
    tick();
    wb0_en = 0;
    check("t2_a", out_opnd_a, 32'hCAFE);
    // double write-back to the same register: wb1 wins
    issue(32'hA3, 4, 4, 0, 3'b110, 0, 1);
    wb0_en = 1; wb0_addr = 4; wb0_data = 32'hAAAA;
    wb1_en = 1; wb1_addr = 4; wb1_data = 32'hBBBB;
    tick();
    wb0_en = 0; wb1_en = 0;
    check("t3_a", out_opnd_a, 32'hBBBB);
    check("t3_b", out_opnd_b, 32'hBBBB);
    // R0 sources read zero and rd=0 never becomes pending
    issue(32'hA4, 0, 0, 0, 3'b111, 0, 1);
    wb0_en = 1; wb0_addr = 0; wb0_data = 32'h1234;
    #1 check("t4_ready", 32'(in_ready), 1);
    tick();
    wb0_en = 0;
    check("t4_a", out_opnd_a, 0);
    issue(32'hA5, 0, 0, 0, 3'b100, 0, 1);
    tick();
    idle();
    wb1_en = 1; wb1_addr = 8; wb1_data = 32'h88;
    tick();
    wb1_en = 0;
    // back-pressure holds the output and blocks intake
    issue(32'hB1, 1, 2, 3, 3'b111, 10, 1);
    tick();
    out_ready = 0;
    issue(32'hB2, 11, 0, 0, 3'b100, 12, 1);
    repeat (3) begin
      tick();
      check("t5_hold", out_instr, 32'hB1);
    end
    out_ready = 1;
    #1 check("t5_ready", 32'(in_ready), 1);
    tick();
    check("t5_next", out_instr, 32'hB2);
    // flush discards the output and releases its pending destination
    idle();
    tick();
    issue(32'hC1, 0, 0, 0, 3'b000, 9, 1);
    tick();
    out_ready = 0;
    flush = 1;
    issue(32'hC2, 9, 0, 0, 3'b100, 13, 1);
    #1 check("t6_flush_rdy", 32'(in_ready), 0);
    tick();
    flush = 0;
    check("t6_flush_v", 32'(out_valid), 0);
    #1 check("t6_r9_free", 32'(in_ready), 1);
    tick();
    // reset while stalled drops everything immediately
    issue(32'hD1, 13, 0, 0, 3'b100, 14, 1);
    repeat (2) tick();
    #2 rst_n = 0;
    #1;
    check("t7_valid", 32'(out_valid), 0);
    check("t7_instr", out_instr, 0);
    check("t7_opnd", out_opnd_a | out_opnd_b | out_opnd_x, 0);
    check("t7_rd", 32'({out_rd, out_rd_we}), 0);
    mp = 0;
    mv = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    tick();
    check("t7_after", out_instr, 32'hD1);
    idle();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
